// File: rtl/conf_link_ctrl.sv
// Frames RS232 bytes into register-bank writes (A5 + NBYTES data) and byte-serial readbacks (5A).
// Registered outputs, 1 clk after the sampled input; readback paces itself on tx_busy, stray rx bytes dropped.
module conf_link_ctrl #(
  parameter int         NBYTES      = 11,
  parameter logic [7:0] CMD_WR      = 8'hA5,
  parameter logic [7:0] CMD_RD      = 8'h5A,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic       shift_rxregs,
  output logic       load_confregs,
  output logic       load_txregs,
  output logic       shift_txregs,
  output logic       busy,
  output logic       cfg_updated,
  output logic       err
);

  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]    LAST_BYTE = 4'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_COMMIT,
    RD_LOAD,
    RD_START,
    RD_WAIT,
    RD_SHIFT
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    bcnt, bcnt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          seen_busy, seen_busy_nxt;
  logic          tx_start_nxt, shift_rxregs_nxt, load_confregs_nxt, load_txregs_nxt;
  logic          shift_txregs_nxt, busy_nxt, cfg_updated_nxt, err_nxt;
  logic          in_rd;

  assign in_rd = (state == RD_LOAD) || (state == RD_START) ||
                 (state == RD_WAIT) || (state == RD_SHIFT);

  always_comb begin
    state_nxt         = state;
    bcnt_nxt          = bcnt;
    tcnt_nxt          = tcnt;
    seen_busy_nxt     = seen_busy;
    err_nxt           = err;
    tx_start_nxt      = 1'b0;
    shift_rxregs_nxt  = 1'b0;
    load_confregs_nxt = 1'b0;
    load_txregs_nxt   = 1'b0;
    shift_txregs_nxt  = 1'b0;
    cfg_updated_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR) begin
            state_nxt = WR_DATA;
            bcnt_nxt  = 4'd0;
            tcnt_nxt  = '0;
            err_nxt   = 1'b0;
          end else if (rx_data == CMD_RD) begin
            state_nxt = RD_LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WR_DATA: begin
        // A byte arriving on the expiry cycle still counts and restarts the idle timer.
        if (rx_valid) begin
          shift_rxregs_nxt = 1'b1;
          tcnt_nxt         = '0;
          bcnt_nxt         = bcnt + 4'd1;
          if (bcnt == LAST_BYTE) state_nxt = WR_COMMIT;
        end else if (tcnt == TMO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      WR_COMMIT: begin
        load_confregs_nxt = 1'b1;
        cfg_updated_nxt   = 1'b1;
        state_nxt         = IDLE;
      end
      RD_LOAD: begin
        load_txregs_nxt = 1'b1;
        bcnt_nxt        = 4'd0;
        state_nxt       = RD_START;
      end
      RD_START: begin
        if (!tx_busy) begin
          tx_start_nxt  = 1'b1;
          seen_busy_nxt = 1'b0;
          state_nxt     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // The transmitter raises busy a cycle or more after tx_start; wait for the full rise/fall.
        if (seen_busy && !tx_busy) begin
          state_nxt = RD_SHIFT;
        end else if (tx_busy) begin
          seen_busy_nxt = 1'b1;
        end
      end
      RD_SHIFT: begin
        shift_txregs_nxt = 1'b1;
        bcnt_nxt         = bcnt + 4'd1;
        state_nxt        = (bcnt == LAST_BYTE) ? IDLE : RD_START;
      end
      default: state_nxt = IDLE;
    endcase

    if (rx_valid && in_rd) err_nxt = 1'b1;

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bcnt          <= 4'd0;
      tcnt          <= '0;
      seen_busy     <= 1'b0;
      tx_start      <= 1'b0;
      shift_rxregs  <= 1'b0;
      load_confregs <= 1'b0;
      load_txregs   <= 1'b0;
      shift_txregs  <= 1'b0;
      busy          <= 1'b0;
      cfg_updated   <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      bcnt          <= bcnt_nxt;
      tcnt          <= tcnt_nxt;
      seen_busy     <= seen_busy_nxt;
      tx_start      <= tx_start_nxt;
      shift_rxregs  <= shift_rxregs_nxt;
      load_confregs <= load_confregs_nxt;
      load_txregs   <= load_txregs_nxt;
      shift_txregs  <= shift_txregs_nxt;
      busy          <= busy_nxt;
      cfg_updated   <= cfg_updated_nxt;
      err           <= err_nxt;
    end
  end

endmodule

// File: tb/tb_conf_link_ctrl.sv
// Scoreboarded bench for conf_link_ctrl: expected strobes are queued with stimulus and popped by a monitor.
module tb_conf_link_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_start, shift_rxregs, load_confregs, load_txregs, shift_txregs;
  logic       busy, cfg_updated, err;

  conf_link_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_start(tx_start), .shift_rxregs(shift_rxregs), .load_confregs(load_confregs),
    .load_txregs(load_txregs), .shift_txregs(shift_txregs), .busy(busy),
    .cfg_updated(cfg_updated), .err(err)
  );

  always #5 clk = ~clk;

  // strobe vector: {tx_start, shift_rxregs, load_confregs, cfg_updated, load_txregs, shift_txregs}
  localparam logic [5:0] E_TX  = 6'b100000;
  localparam logic [5:0] E_SRX = 6'b010000;
  localparam logic [5:0] E_LCF = 6'b001100;
  localparam logic [5:0] E_LTX = 6'b000010;
  localparam logic [5:0] E_STX = 6'b000001;

  typedef struct {
    int         c;
    logic [5:0] s;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_tx = 0, n_srx = 0, n_lcf = 0, n_ltx = 0, n_stx = 0;
  logic last_stx_busy = 1'b1;
  logic [5:0] obs;
  ev_t  e;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for 20 cycles, starting the cycle after tx_start.
  logic saw_start = 1'b0;
  int   tx_cnt = 0;
  always @(negedge clk) if (tx_start === 1'b1) saw_start = 1'b1;
  always @(posedge clk) begin
    #1;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_busy = 1'b0;
    end else if (saw_start) begin
      tx_busy   = 1'b1;
      tx_cnt    = 20;
      saw_start = 1'b0;
    end
  end

  // Monitor: every strobe observed must match the head of the expected queue.
  always @(negedge clk) begin
    obs = {tx_start, shift_rxregs, load_confregs, cfg_updated, load_txregs, shift_txregs};
    if (tx_start === 1'b1) n_tx++;
    if (shift_rxregs === 1'b1) n_srx++;
    if (load_confregs === 1'b1) n_lcf++;
    if (load_txregs === 1'b1) n_ltx++;
    if (shift_txregs === 1'b1) begin
      n_stx++;
      last_stx_busy = busy;
    end
    if (obs != 6'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: cycle %0d got %b, expected none", cyc, obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.s || (e.c >= 0 && cyc != e.c)) begin
          errors++;
          $display("FAIL strobe_seq: cycle %0d got %b, expected %b at cycle %0d", cyc, obs, e.s, e.c);
        end
      end
    end
    if (tx_start === 1'b1) begin
      checks++;
      if (tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL tx_start_busy: cycle %0d tx_busy=%b, required 0", cyc, tx_busy);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int c);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    c        = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({obs, busy, err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000000", {obs, busy, err});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: busy/err got %b, required 00", {busy, err});
    end
  endtask

  task automatic test_bad_header();
    int c;
    send_byte(8'h00, c);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_header: err=%b busy=%b, required err=1 busy=0", err, busy);
    end
  endtask

  task automatic test_write();
    int c, c_prev, l0;
    l0 = n_lcf;
    c_prev = 0;
    send_byte(8'hA5, c);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_header: err=%b busy=%b, required err=0 busy=1", err, busy);
    end
    for (int i = 1; i <= 11; i++) begin
      // byte 6 lands exactly on the idle-timeout expiry cycle
      if (i == 6) repeat (c_prev + 99 - cyc) @(posedge clk);
      send_byte(8'(i), c);
      exp_q.push_back('{c + 1, E_SRX});
      if (i == 11) exp_q.push_back('{c + 2, E_LCF});
      c_prev = c;
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wr_complete: %0d strobes outstanding, required 0", exp_q.size());
    end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || n_lcf - l0 != 1) begin
      errors++;
      $display("FAIL wr_end: err=%b busy=%b loads=%0d, required 0 0 1", err, busy, n_lcf - l0);
    end
  endtask

  task automatic test_readback(input bit inject);
    int c, t0, l0, s0, r0;
    t0 = n_tx; l0 = n_ltx; s0 = n_stx; r0 = n_srx;
    exp_q.push_back('{-1, E_LTX});
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back('{-1, E_TX});
      exp_q.push_back('{-1, E_STX});
    end
    send_byte(8'h5A, c);
    if (inject) begin
      for (int i = 0; i < 500 && n_tx - t0 < 3; i++) @(negedge clk);
      checks++;
      if (n_tx - t0 < 3) begin
        errors++;
        $display("FAIL rd_third_start: tx_start count %0d, required 3", n_tx - t0);
      end
      send_byte(8'h33, c);
    end
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_complete: %0d strobes outstanding, required 0", exp_q.size());
    end
    checks++;
    if (n_tx - t0 != 11 || n_stx - s0 != 11 || n_ltx - l0 != 1 || n_srx != r0) begin
      errors++;
      $display("FAIL rd_counts: tx=%0d shift=%0d load=%0d rxshift=%0d, required 11 11 1 0",
               n_tx - t0, n_stx - s0, n_ltx - l0, n_srx - r0);
    end
    checks++;
    if (busy !== 1'b0 || last_stx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_busy_end: busy=%b at_last_shift=%b, required 0 0", busy, last_stx_busy);
    end
    checks++;
    if (err !== inject) begin
      errors++;
      $display("FAIL rd_err: err=%b, required %b", err, inject);
    end
  endtask

  task automatic test_timeout();
    int c, l0;
    l0 = n_lcf;
    send_byte(8'hA5, c);
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i + 8'h10), c);
      exp_q.push_back('{c + 1, E_SRX});
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL to_err_cleared: err=%b, required 0", err);
    end
    while (cyc < c + 100) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL to_early: busy=%b err=%b, required 1 0", busy, err);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL to_expire: busy=%b err=%b, required 0 1", busy, err);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_lcf != l0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL to_noload: loads=%0d outstanding=%0d, required 0 0", n_lcf - l0, exp_q.size());
    end
  endtask

  task automatic test_reset_midwrite();
    int c, l0, r0;
    l0 = n_lcf;
    send_byte(8'hA5, c);
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i), c);
      exp_q.push_back('{c + 1, E_SRX});
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({obs, busy, err} !== 8'b0) begin
      errors++;
      $display("FAIL rstw_outputs: got %b, required 00000000", {obs, busy, err});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    r0 = n_srx;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), c);
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || n_lcf != l0 || n_srx != r0) begin
      errors++;
      $display("FAIL rstw_after: err=%b busy=%b loads=%0d shifts=%0d, required 1 0 0 0",
               err, busy, n_lcf - l0, n_srx - r0);
    end
  endtask

  task automatic test_reset_midread();
    int c, t0;
    t0 = n_tx;
    exp_q.push_back('{-1, E_LTX});
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back('{-1, E_TX});
      exp_q.push_back('{-1, E_STX});
    end
    send_byte(8'h5A, c);
    for (int i = 0; i < 500 && n_tx - t0 < 2; i++) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({obs, busy, err} !== 8'b0) begin
      errors++;
      $display("FAIL rstr_outputs: got %b, required 00000000", {obs, busy, err});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (n_tx - t0 != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstr_after: tx_start=%0d busy=%b, required 2 0", n_tx - t0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_bad_header();
    test_write();
    test_readback(1'b0);
    test_readback(1'b1);
    test_timeout();
    test_reset_midwrite();
    test_reset_midread();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conf_link_ctrl.md
CONF_LINK_CTRL -- requirements
Module: conf_link_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 11: configuration frame length in bytes (88-bit register bank / 8).
REQ-002 SHALL have parameter CMD_WR, default 8'hA5: header byte opening a configuration write.
REQ-003 SHALL have parameter CMD_RD, default 8'h5A: header byte requesting configuration readback.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1_000_000: maximum idle clk cycles between write-frame bytes.
REQ-005 SHALL have ports, one per line:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received byte from RS232 receiver, held stable until the next rx_valid
- rx_valid  input  1  one-cycle pulse, new byte on rx_data
- tx_busy  input  1  RS232 transmitter busy
- tx_start  output  1  one-cycle pulse, transmit the byte currently on the register-bank txdw
- shift_rxregs  output  1  one-cycle pulse, shift one byte into the RX shift register
- load_confregs  output  1  one-cycle pulse, commit RX shift register into configuration registers
- load_txregs  output  1  one-cycle pulse, copy configuration registers into the TX shift register
- shift_txregs  output  1  one-cycle pulse, advance the TX shift register by one byte
- busy  output  1  high whenever state is not IDLE
- cfg_updated  output  1  one-cycle pulse, coincident with load_confregs
- err  output  1  sticky error flag: timeout, unknown header, or byte dropped during readback

Function
REQ-006 SHALL implement FSM states IDLE, WR_DATA, WR_COMMIT, RD_LOAD, RD_START, RD_WAIT, RD_SHIFT.
REQ-007 All outputs SHALL be registered. Every strobe SHALL be high for exactly one clk cycle per event.
REQ-008 In IDLE, rx_valid with rx_data==CMD_WR SHALL go to WR_DATA, clear byte counter and timeout counter.
REQ-009 In IDLE, rx_valid with rx_data==CMD_RD SHALL go to RD_LOAD.
REQ-010 In IDLE, rx_valid with any other value SHALL set err and stay in IDLE. No strobe SHALL be issued.
REQ-011 In WR_DATA, each rx_valid SHALL produce shift_rxregs in the following cycle, increment the byte counter (4 bits), and clear the timeout counter.
REQ-012 A header byte value received inside WR_DATA SHALL be treated as data.
REQ-013 When the NBYTES-th data byte is shifted, the FSM SHALL enter WR_COMMIT.
REQ-014 WR_COMMIT SHALL pulse load_confregs and cfg_updated for one cycle, then return to IDLE. Total latency: last rx_valid -> shift_rxregs at +1 cycle -> load_confregs at +2 cycles.
REQ-015 In WR_DATA the timeout counter SHALL increment every cycle without rx_valid. On reaching TIMEOUT_CYC it SHALL set err and return to IDLE without load_confregs, so the configuration registers are left unchanged.
REQ-016 If rx_valid and timeout expiry coincide, rx_valid SHALL win: the byte is accepted and the counter is cleared.
REQ-017 RD_LOAD SHALL pulse load_txregs, clear the byte counter, and go to RD_START.
REQ-018 RD_START SHALL wait until tx_busy==0, then pulse tx_start and go to RD_WAIT.
REQ-019 RD_WAIT SHALL first see tx_busy==1 and then tx_busy==0 (transmission completed), then go to RD_SHIFT.
REQ-020 RD_SHIFT SHALL pulse shift_txregs and increment the byte counter. It SHALL return to RD_START while the count is below NBYTES, otherwise go to IDLE.
REQ-021 A readback SHALL therefore emit exactly NBYTES tx_start pulses, with the low byte of the configuration transmitted first. There SHALL be exactly one load_txregs per readback and it SHALL precede the first tx_start.
REQ-022 rx_valid during any RD_* state SHALL be dropped: no strobe is issued, err is set, and the sequence continues.
REQ-023 load_confregs and load_txregs SHALL never be asserted in the same cycle. shift_rxregs and shift_txregs SHALL be mutually exclusive.
REQ-024 err SHALL clear only on reset or on acceptance of a CMD_WR header.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, clear both counters, and drive every output to 0.
REQ-026 Reset in mid-write SHALL discard the partial frame, with no load_confregs issued after release.
REQ-027 Reset in mid-readback SHALL abort transmission scheduling, with no further tx_start.
REQ-028 After rst_n deasserts, the first clk edge SHALL be evaluated in IDLE.

Verification
REQ-029 Write A5 then bytes 01..0B -> 11 shift_rxregs pulses, each 1 cycle after its rx_valid; load_confregs and cfg_updated 2 cycles after the 0B rx_valid; err=0.
REQ-030 Write A5 then 5 bytes, then silence for TIMEOUT_CYC (set to 100) -> err=1, busy=0, no load_confregs.
REQ-031 Send 5A with a tx model holding busy for 20 cycles -> 1 load_txregs then 11 tx_start/shift_txregs pairs; each tx_start only while tx_busy=0; busy falls after the 11th shift.
REQ-032 Send 5A, then inject rx_valid (8'h33) during the 3rd transmission -> err=1, still exactly 11 tx_start pulses, no shift_rxregs.
REQ-033 Send header 8'h00 in IDLE -> err=1, no strobes; then A5 -> err clears.
REQ-034 Assert rst_n low after A5 plus 6 bytes, release, then send 5 bytes -> no load_confregs; the bytes are treated as unknown headers and err=1.
